// File: rtl/ir_queue.sv
// Instruction queue: DEPTH-entry circular buffer of instruction words with
// combinational LC-3b field decode of the head entry.
module ir_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned WIDTH  = 16,
  localparam int unsigned CountW = $clog2(DEPTH + 1),
  localparam int unsigned AddrW  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CountW-1:0] count,
  output logic [3:0]        opcode,
  output logic [2:0]        dest,
  output logic [2:0]        src1,
  output logic [2:0]        src2,
  output logic [5:0]        offset6,
  output logic [8:0]        offset9,
  output logic [10:0]       offset11,
  output logic [4:0]        imm5,
  output logic              imm5_enable,
  output logic              offset11_enable
);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [AddrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AddrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CountW-1:0] count_q, count_d;
  logic              enq, deq;
  logic [15:0]       head;

  // in_ready deliberately ignores out_ready: a full queue never accepts.
  assign in_ready  = (count_q < CountW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign count     = count_q;
  assign enq       = in_valid && in_ready;
  assign deq       = out_valid && out_ready;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + AddrW'(1);
      if (deq) rd_ptr_d = rd_ptr_q + AddrW'(1);
      unique case ({enq, deq})
        2'b10:   count_d = count_q + CountW'(1);
        2'b01:   count_d = count_q - CountW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never reset; stale entries are masked by out_valid below.
  always_ff @(posedge clk) begin
    if (enq && !flush && !reset) begin
      mem_q[wr_ptr_q] <= in;
    end
  end

  assign head = out_valid ? mem_q[rd_ptr_q][15:0] : 16'h0000;

  assign opcode          = head[15:12];
  assign dest            = head[11:9];
  assign src1            = head[8:6];
  assign src2            = head[2:0];
  assign offset6         = head[5:0];
  assign offset9         = head[8:0];
  assign offset11        = head[10:0];
  assign imm5            = head[4:0];
  assign imm5_enable     = head[5];
  assign offset11_enable = head[11];

endmodule

// File: tb/tb_ir_queue.sv
// Self-checking bench for ir_queue: directed scenarios plus randomized traffic
// compared against a queue-based behavioural model.
module tb_ir_queue;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              reset, flush, in_valid, out_ready;
  logic [WIDTH-1:0]  in;
  logic              in_ready, out_valid;
  logic [CW-1:0]     count;
  logic [3:0]        opcode;
  logic [2:0]        dest, src1, src2;
  logic [5:0]        offset6;
  logic [8:0]        offset9;
  logic [10:0]       offset11;
  logic [4:0]        imm5;
  logic              imm5_enable, offset11_enable;

  int checks = 0;
  int errors = 0;

  logic [15:0] model_q[$];
  logic [45:0] got_fields;

  ir_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in(in),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .count(count),
    .opcode(opcode), .dest(dest), .src1(src1), .src2(src2), .offset6(offset6),
    .offset9(offset9), .offset11(offset11), .imm5(imm5), .imm5_enable(imm5_enable),
    .offset11_enable(offset11_enable)
  );

  always #5 clk = ~clk;

  assign got_fields = {opcode, dest, src1, src2, offset6, offset9, offset11, imm5,
                       imm5_enable, offset11_enable};

  // Expected decode of an LC-3b word; all-zero when nothing is at the head.
  function automatic logic [45:0] exp_fields();
    logic [15:0] w;
    w = (model_q.size() != 0) ? model_q[0] : 16'h0000;
    return {w[15:12], w[11:9], w[8:6], w[2:0], w[5:0], w[8:0], w[10:0], w[4:0],
            w[5], w[11]};
  endfunction

  // Advance the model using the inputs as they stand, then clock the DUT.
  task automatic step();
    logic enq, deq;
    enq = in_valid && (model_q.size() < DEPTH);
    deq = out_ready && (model_q.size() != 0);
    if (reset || flush) begin
      model_q.delete();
    end else begin
      if (deq) void'(model_q.pop_front());
      if (enq) model_q.push_back(in);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    in = 16'hffff;
    do_reset();
    checks++;
    if ({in_ready, out_valid, count} !== {1'b1, 1'b0, CW'(0)}) begin
      errors++;
      $display("FAIL reset_state got rdy/vld/cnt=%b/%b/%0d want 1/0/0", in_ready, out_valid,
               count);
    end
    checks++;
    if (got_fields !== 46'd0) begin
      errors++;
      $display("FAIL reset_fields got %h want 0", got_fields);
    end
  endtask

  task automatic test_single();
    do_reset();
    in_valid = 1'b1; in = 16'h1283;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_no_bypass got out_valid=%b want 0", out_valid);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, opcode, dest, src1, src2, imm5_enable, count} !==
        {1'b1, 4'h1, 3'd1, 3'd2, 3'd3, 1'b0, CW'(1)}) begin
      errors++;
      $display("FAIL single_decode got v=%b op=%h d=%0d s1=%0d s2=%0d ie=%b cnt=%0d", out_valid,
               opcode, dest, src1, src2, imm5_enable, count);
    end
    checks++;
    if (got_fields !== exp_fields()) begin
      errors++;
      $display("FAIL single_fields got %h want %h", got_fields, exp_fields());
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1; in = 16'(16'hA000 + i);
      step();
    end
    checks++;
    if ({count, in_ready} !== {CW'(DEPTH), 1'b0}) begin
      errors++;
      $display("FAIL fill_full got cnt=%0d rdy=%b want %0d/0", count, in_ready, DEPTH);
    end
    in = 16'hBEEF;
    step();
    in_valid = 1'b0;
    checks++;
    if ({count, opcode, offset11} !== {CW'(DEPTH), 4'hA, 11'h000}) begin
      errors++;
      $display("FAIL fill_ignore got cnt=%0d op=%h off11=%h want %0d/a/000", count, opcode,
               offset11, DEPTH);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] expect_head;
    do_reset();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in = 16'(16'h5021 + i);
      if (i > 0) begin
        expect_head = 16'(16'h5021 + i - 1);
        checks++;
        if ({out_valid, opcode, dest, src1, offset6} !==
            {1'b1, expect_head[15:12], expect_head[11:9], expect_head[8:6],
             expect_head[5:0]}) begin
          errors++;
          $display("FAIL wrap_order[%0d] got v=%b op=%h off6=%h want head %h", i, out_valid,
                   opcode, offset6, expect_head);
        end
      end
      step();
      checks++;
      if (count !== CW'(1)) begin
        errors++;
        $display("FAIL wrap_count[%0d] got %0d want 1", i, count);
      end
    end
    idle();
  endtask

  task automatic test_full_deq();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1; in = 16'(16'h3000 + 16'(i) * 16'h0041);
      step();
    end
    in = 16'hF1F1; out_ready = 1'b1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL fulldeq_ready got %b want 0", in_ready);
    end
    step();
    idle();
    checks++;
    if ({count, in_ready} !== {CW'(DEPTH - 1), 1'b1}) begin
      errors++;
      $display("FAIL fulldeq_count got cnt=%0d rdy=%b want %0d/1", count, in_ready, DEPTH - 1);
    end
    // Drain and confirm the rejected word never shows up.
    out_ready = 1'b1;
    for (int i = 1; i < DEPTH; i++) begin
      checks++;
      if (got_fields !== exp_fields() || opcode === 4'hF) begin
        errors++;
        $display("FAIL fulldeq_drain[%0d] got %h want %h", i, got_fields, exp_fields());
      end
      step();
    end
    idle();
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in = 16'(16'h7123 + i);
      step();
    end
    flush = 1'b1; in = 16'hE555;
    step();
    idle();
    checks++;
    if ({count, out_valid, got_fields} !== {CW'(0), 1'b0, 46'd0}) begin
      errors++;
      $display("FAIL flush_clear got cnt=%0d v=%b f=%h want 0/0/0", count, out_valid,
               got_fields);
    end
    in_valid = 1'b1; in = 16'h2abc;
    step();
    idle();
    checks++;
    if ({count, opcode, offset11} !== {CW'(1), 4'h2, 11'h2bc}) begin
      errors++;
      $display("FAIL flush_dropped got cnt=%0d op=%h off11=%h want 1/2/2bc", count, opcode,
               offset11);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in = 16'(16'h9000 + i);
      step();
    end
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in = 16'h4444;
    step();
    idle();
    checks++;
    if ({count, in_ready, out_valid, got_fields} !== {CW'(0), 1'b1, 1'b0, 46'd0}) begin
      errors++;
      $display("FAIL resetmid got cnt=%0d rdy=%b v=%b f=%h want 0/1/0/0", count, in_ready,
               out_valid, got_fields);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      reset     = ($urandom_range(0, 39) == 0);
      in        = 16'($urandom);
      step();
      checks++;
      if ({count, in_ready, out_valid} !==
          {CW'(model_q.size()), model_q.size() < DEPTH, model_q.size() != 0}) begin
        errors++;
        $display("FAIL random_state[%0d] got cnt=%0d rdy=%b v=%b want cnt=%0d", i, count,
                 in_ready, out_valid, model_q.size());
      end
      checks++;
      if (got_fields !== exp_fields()) begin
        errors++;
        $display("FAIL random_fields[%0d] got %h want %h", i, got_fields, exp_fields());
      end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_single();
    test_fill();
    test_wrap();
    test_full_deq();
    test_flush();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
